// File: rtl/dm_responder.sv
// Data-memory responder for the pipelined core: word RAM with byte-enabled sub-word stores and
// right-aligned, extended loads returned after RD_LATENCY cycles.
module dm_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w,
  input  logic        mem_r,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  input  logic [2:0]  DMType,
  output logic [31:0] Data_out,
  output logic        rd_valid,
  output logic        busy,
  output logic        misalign_err,
  output logic        ovr_err
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [1:0]              off_q;
  logic [2:0]              type_q;
  logic                    mis_q;
  logic [31:0]             data_out_q, data_out_d;
  logic                    rd_valid_q, misalign_q, misalign_d, ovr_q, ovr_d;

  logic [31:0]             mem [Depth];

  logic [ADDR_WIDTH-1:0]   cur_idx, rd_idx;
  logic [1:0]              cur_off, rd_off;
  logic [2:0]              rd_type;
  logic                    cur_aligned, rd_mis;
  logic                    accept, accept_wr, accept_rd, enter_resp, we;
  logic [3:0]              be;
  logic [31:0]             wdata, rd_word, rd_ext;
  logic [15:0]             rd_half;
  logic [7:0]              rd_byte;
  logic                    unused_addr;

  assign cur_idx     = Addr_in[ADDR_WIDTH+1:2];
  assign cur_off     = Addr_in[1:0];
  assign unused_addr = ^Addr_in[31:ADDR_WIDTH+2];

  always_comb begin
    cur_aligned = 1'b0;
    be          = 4'b0000;
    wdata       = Data_in;
    unique case (DMType)
      3'b000: begin
        cur_aligned = (cur_off == 2'b00);
        be          = 4'b1111;
      end
      3'b001, 3'b010: begin
        cur_aligned = ~cur_off[0];
        be          = cur_off[1] ? 4'b1100 : 4'b0011;
        wdata       = {2{Data_in[15:0]}};
      end
      3'b011, 3'b100: begin
        cur_aligned = 1'b1;
        be          = 4'b0001 << cur_off;
        wdata       = {4{Data_in[7:0]}};
      end
      default: cur_aligned = 1'b0;
    endcase
  end

  // Requests arriving during WAIT are dropped; store has priority over load.
  assign accept    = (state_q != StWait);
  assign accept_wr = accept & mem_w;
  assign accept_rd = accept & mem_r & ~mem_w;
  assign we        = accept_wr & cur_aligned;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[cur_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Single-cycle latency reads straight from the request; longer latencies use latched fields.
  assign rd_idx  = (state_q == StWait) ? idx_q  : cur_idx;
  assign rd_off  = (state_q == StWait) ? off_q  : cur_off;
  assign rd_type = (state_q == StWait) ? type_q : DMType;
  assign rd_mis  = (state_q == StWait) ? mis_q  : ~cur_aligned;
  assign rd_word = mem[rd_idx];
  assign rd_half = rd_off[1] ? rd_word[31:16] : rd_word[15:0];
  assign rd_byte = 8'(rd_word >> {rd_off, 3'b000});

  always_comb begin
    unique case (rd_type)
      3'b000:  rd_ext = rd_word;
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  rd_ext = {16'h0000, rd_half};
      3'b011:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rd_ext = {24'h000000, rd_byte};
      default: rd_ext = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    if (state_q == StWait) begin
      if (cnt_q == 2'd1) begin
        state_d    = StResp;
        enter_resp = 1'b1;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (accept_rd) begin
      cnt_d = 2'(RD_LATENCY - 1);
      if (RD_LATENCY == 1) begin
        state_d    = StResp;
        enter_resp = 1'b1;
      end else begin
        state_d = StWait;
      end
    end else begin
      state_d = StIdle;
    end
    data_out_d = data_out_q;
    if (enter_resp) data_out_d = rd_mis ? 32'h0 : rd_ext;
    misalign_d = (accept_wr & ~cur_aligned) | (enter_resp & rd_mis);
    ovr_d      = ovr_q | ((state_q == StWait) & (mem_w | mem_r));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      idx_q      <= '0;
      off_q      <= 2'b00;
      type_q     <= 3'b000;
      mis_q      <= 1'b0;
      data_out_q <= 32'h0;
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      rd_valid_q <= enter_resp;
      misalign_q <= misalign_d;
      ovr_q      <= ovr_d;
      if (accept_rd) begin
        idx_q  <= cur_idx;
        off_q  <= cur_off;
        type_q <= DMType;
        mis_q  <= ~cur_aligned;
      end
    end
  end

  assign Data_out     = data_out_q;
  assign rd_valid     = rd_valid_q;
  assign busy         = (state_q == StWait);
  assign misalign_err = misalign_q;
  assign ovr_err      = ovr_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: table-driven vectors on a latency-1 instance, hand sequences
// for busy/overrun/back-to-back/reset-abort on a latency-3 instance.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst1, w1, r1;
  logic [31:0] a1, d1;
  logic [2:0]  t1;
  logic [31:0] q1;
  logic        rv1, bz1, me1, oe1;
  logic        rst3, w3, r3;
  logic [31:0] a3, d3;
  logic [2:0]  t3;
  logic [31:0] q3;
  logic        rv3, bz3, me3, oe3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_WIDTH(10), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst1), .mem_w(w1), .mem_r(r1), .Addr_in(a1), .Data_in(d1), .DMType(t1),
    .Data_out(q1), .rd_valid(rv1), .busy(bz1), .misalign_err(me1), .ovr_err(oe1)
  );

  dm_responder #(.ADDR_WIDTH(10), .RD_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst3), .mem_w(w3), .mem_r(r3), .Addr_in(a3), .Data_in(d3), .DMType(t3),
    .Data_out(q3), .rd_valid(rv3), .busy(bz3), .misalign_err(me3), .ovr_err(oe3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // op: 0 store, 1 load, 2 store+load together
  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  typ;
    logic [31:0] exp;
    logic        exp_mis;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];
  logic [31:0] last;

  initial begin
    vecs[0]  = '{2'd0, 32'h10,   32'h12345678, 3'b000, 32'h0,        1'b0};
    vecs[1]  = '{2'd1, 32'h10,   32'h0,        3'b000, 32'h12345678, 1'b0};
    vecs[2]  = '{2'd0, 32'h11,   32'h55AACCAB, 3'b011, 32'h0,        1'b0};
    vecs[3]  = '{2'd1, 32'h11,   32'h0,        3'b011, 32'hFFFFFFAB, 1'b0};
    vecs[4]  = '{2'd1, 32'h11,   32'h0,        3'b100, 32'h000000AB, 1'b0};
    vecs[5]  = '{2'd1, 32'h10,   32'h0,        3'b000, 32'h1234AB78, 1'b0};
    vecs[6]  = '{2'd1, 32'h12,   32'h0,        3'b011, 32'h00000034, 1'b0};
    vecs[7]  = '{2'd1, 32'h13,   32'h0,        3'b100, 32'h00000012, 1'b0};
    vecs[8]  = '{2'd1, 32'h10,   32'h0,        3'b001, 32'hFFFFAB78, 1'b0};
    vecs[9]  = '{2'd0, 32'h20,   32'h00000000, 3'b000, 32'h0,        1'b0};
    vecs[10] = '{2'd0, 32'h22,   32'h77778001, 3'b001, 32'h0,        1'b0};
    vecs[11] = '{2'd1, 32'h22,   32'h0,        3'b001, 32'hFFFF8001, 1'b0};
    vecs[12] = '{2'd1, 32'h22,   32'h0,        3'b010, 32'h00008001, 1'b0};
    vecs[13] = '{2'd1, 32'h20,   32'h0,        3'b000, 32'h80010000, 1'b0};
    vecs[14] = '{2'd0, 32'h13,   32'hDEADBEEF, 3'b000, 32'h0,        1'b1};
    vecs[15] = '{2'd1, 32'h10,   32'h0,        3'b000, 32'h1234AB78, 1'b0};
    vecs[16] = '{2'd1, 32'h15,   32'h0,        3'b001, 32'h00000000, 1'b1};
    vecs[17] = '{2'd0, 32'h10,   32'hFFFFFFFF, 3'b111, 32'h0,        1'b1};
    vecs[18] = '{2'd1, 32'h10,   32'h0,        3'b101, 32'h00000000, 1'b1};
    vecs[19] = '{2'd1, 32'h10,   32'h0,        3'b000, 32'h1234AB78, 1'b0};
    vecs[20] = '{2'd2, 32'h24,   32'hCAFEF00D, 3'b000, 32'h0,        1'b0};
    vecs[21] = '{2'd1, 32'h24,   32'h0,        3'b000, 32'hCAFEF00D, 1'b0};
    vecs[22] = '{2'd0, 32'h1023, 32'h0000007F, 3'b011, 32'h0,        1'b0};
    vecs[23] = '{2'd1, 32'h1010, 32'h0,        3'b000, 32'h1234AB78, 1'b0};

    rst1 = 1'b0; rst3 = 1'b0;
    w1 = 0; r1 = 0; a1 = 0; d1 = 0; t1 = 0;
    w3 = 0; r3 = 0; a3 = 0; d3 = 0; t3 = 0;
    step();
    step();
    chk("rst_data", q1, 32'h0);
    chk("rst_valid", {31'h0, rv1}, 32'h0);
    chk("rst_busy", {31'h0, bz3}, 32'h0);
    chk("rst_mis", {31'h0, me1}, 32'h0);
    chk("rst_ovr", {31'h0, oe3}, 32'h0);
    rst1 = 1'b1; rst3 = 1'b1;
    step();

    last = 32'h0;
    for (int i = 0; i < NV; i++) begin
      w1 = (vecs[i].op != 2'd1);
      r1 = (vecs[i].op != 2'd0);
      a1 = vecs[i].addr;
      d1 = vecs[i].data;
      t1 = vecs[i].typ;
      step();
      w1 = 0; r1 = 0;
      if (vecs[i].op == 2'd1) begin
        chk($sformatf("v%0d_valid", i), {31'h0, rv1}, 32'h1);
        chk($sformatf("v%0d_data", i), q1, vecs[i].exp);
        last = vecs[i].exp;
      end else begin
        chk($sformatf("v%0d_novalid", i), {31'h0, rv1}, 32'h0);
        chk($sformatf("v%0d_hold", i), q1, last);
      end
      chk($sformatf("v%0d_mis", i), {31'h0, me1}, {31'h0, vecs[i].exp_mis});
      chk($sformatf("v%0d_busy", i), {31'h0, bz1}, 32'h0);
      step();
      chk($sformatf("v%0d_idle", i), {30'h0, rv1, me1}, 32'h0);
      chk($sformatf("v%0d_idlehold", i), q1, last);
    end
    chk("lat1_ovr", {31'h0, oe1}, 32'h0);

    // Latency 3: busy window, overrun, back-to-back load in the response cycle.
    w3 = 1; a3 = 32'h10; d3 = 32'h12345678; t3 = 3'b000;
    step();
    a3 = 32'h11; d3 = 32'h000000AB; t3 = 3'b011;
    step();
    w3 = 0;
    r3 = 1; a3 = 32'h10; t3 = 3'b000;
    step();
    r3 = 0;
    chk("l3_e0_busy", {30'h0, bz3, rv3}, 32'h2);
    w3 = 1; a3 = 32'h10; d3 = 32'h0; t3 = 3'b000;
    step();
    w3 = 0;
    chk("l3_e1_busy", {30'h0, bz3, rv3}, 32'h2);
    chk("l3_ovr", {31'h0, oe3}, 32'h1);
    step();
    chk("l3_resp", {30'h0, bz3, rv3}, 32'h1);
    chk("l3_data", q3, 32'h1234AB78);
    r3 = 1; a3 = 32'h12; t3 = 3'b001;
    step();
    r3 = 0;
    chk("l3_b2b_busy", {30'h0, bz3, rv3}, 32'h2);
    chk("l3_b2b_hold", q3, 32'h1234AB78);
    step();
    chk("l3_b2b_busy2", {30'h0, bz3, rv3}, 32'h2);
    step();
    chk("l3_b2b_resp", {30'h0, bz3, rv3}, 32'h1);
    chk("l3_b2b_data", q3, 32'h00001234);
    step();
    chk("l3_b2b_done", {30'h0, bz3, rv3}, 32'h0);

    // Reset in the middle of WAIT aborts the read.
    r3 = 1; a3 = 32'h10; t3 = 3'b000;
    step();
    r3 = 0;
    chk("l3_abort_busy", {31'h0, bz3}, 32'h1);
    #2 rst3 = 1'b0;
    #1;
    chk("l3_abort_outs", {28'h0, bz3, rv3, me3, oe3}, 32'h0);
    chk("l3_abort_data", q3, 32'h0);
    #1 rst3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("l3_norv%0d", k), {30'h0, bz3, rv3}, 32'h0);
    end

    // Aliased address after reset: RAM kept its contents.
    r3 = 1; a3 = 32'h10 + 32'h1000; t3 = 3'b000;
    step();
    r3 = 0;
    step();
    chk("l3_alias_wait", {30'h0, bz3, rv3}, 32'h2);
    step();
    chk("l3_alias_resp", {30'h0, bz3, rv3}, 32'h1);
    chk("l3_alias_data", q3, 32'h1234AB78);
    chk("l3_alias_ovr", {31'h0, oe3}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
